main_mux8: RTL and testbench

- Evaluates two independent 4-input Boolean functions, g and h, of inputs a, b, c, d.
- Each function is built the classic way: an 8:1 multiplexer with {a,b,c} as select and d-derived data inputs, one of 0, 1, d or ~d.
- Outputs are registered on the single system clock.
- Intended as a small glue-logic / function-generator cell inside the control datapath.

---
 rtl/main_mux8_pkg.sv | 41 ++++
 rtl/main_mux8_mux8_1.sv | 13 +
 rtl/main_mux8.sv | 67 ++++++
 tb/tb_main_mux8.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/main_mux8_pkg.sv
// Shared definitions for main_mux8, a registered two-function generator.
//   G_TT_DEFAULT / H_TT_DEFAULT : default 16-entry truth tables, bit {a,b,c,d}
//   src_e                       : source selector for one mux data input
//   tt_to_src(tt, i)            : picks the data source for select index i
//   src_to_bit(src, d)          : turns a data source into a bit, given d
package main_mux8_pkg;

  localparam logic [15:0] G_TT_DEFAULT = 16'hC39A;
  localparam logic [15:0] H_TT_DEFAULT = 16'h3C65;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_ONE  = 2'd1,
    SRC_D    = 2'd2,
    SRC_ND   = 2'd3
  } src_e;

  // Within one select index {a,b,c}, the pair of truth-table bits for d=1
  // and d=0 shows how the function depends on d. This gives four cases:
  // the function is constant 0, constant 1, follows d, or is inverted d.
  function automatic src_e tt_to_src(input logic [15:0] tt, input logic [2:0] i);
    logic [1:0] pair;
    pair = {tt[{i, 1'b1}], tt[{i, 1'b0}]};
    case (pair)
      2'b00:   return SRC_ZERO;
      2'b11:   return SRC_ONE;
      2'b10:   return SRC_D;
      default: return SRC_ND;
    endcase
  endfunction

  function automatic logic src_to_bit(input src_e src, input logic d);
    case (src)
      SRC_ZERO: return 1'b0;
      SRC_ONE:  return 1'b1;
      SRC_D:    return d;
      default:  return ~d;
    endcase
  endfunction

endpackage

// File: rtl/main_mux8_mux8_1.sv
// Plain 8:1 multiplexer, purely combinational.
//   data : 8 data inputs, data[sel] is routed to y
//   sel  : 3-bit select
//   y    : selected bit
module mux8_1 (
  input  logic [7:0] data,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = data[sel];

endmodule

// File: rtl/main_mux8.sv
// Two independent 4-input Boolean functions g and h of (a,b,c,d). Each one
// uses an 8:1 mux with {a,b,c} as the select. Its data inputs are 0, 1, d or
// ~d, and they are derived from the truth-table parameters at elaboration.
// Both results are registered.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset, clears g_out/h_out
//   a,b,c : mux select {a,b,c}, a is the MSB
//   d     : residue variable feeding the mux data inputs
//   g_out : registered g(a,b,c,d), one cycle latency
//   h_out : registered h(a,b,c,d), one cycle latency
module main_mux8
  import main_mux8_pkg::*;
#(
  parameter logic [15:0] G_TT = G_TT_DEFAULT,
  parameter logic [15:0] H_TT = H_TT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic g_out,
  output logic h_out
);

  logic [2:0] sel_p0;
  logic [7:0] g_data_p0;
  logic [7:0] h_data_p0;
  logic       g_p0;
  logic       h_p0;

  assign sel_p0 = {a, b, c};

  // Each mux data input has a fixed source, chosen from the parameters.
  // Only d is used at run time.
  for (genvar i = 0; i < 8; i++) begin : g_src
    localparam src_e G_SRC = tt_to_src(G_TT, 3'(i));
    localparam src_e H_SRC = tt_to_src(H_TT, 3'(i));
    assign g_data_p0[i] = src_to_bit(G_SRC, d);
    assign h_data_p0[i] = src_to_bit(H_SRC, d);
  end

  mux8_1 u_mux_g (
    .data (g_data_p0),
    .sel  (sel_p0),
    .y    (g_p0)
  );

  mux8_1 u_mux_h (
    .data (h_data_p0),
    .sel  (sel_p0),
    .y    (h_p0)
  );

  // ---- stage boundary: combinational result -> output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_out <= 1'b0;
      h_out <= 1'b0;
    end else begin
      g_out <= g_p0;
      h_out <= h_p0;
    end
  end

endmodule

// File: tb/tb_main_mux8.sv
module tb_main_mux8;
  import main_mux8_pkg::*;

  logic clk;
  logic rst_n;
  logic a, b, c, d;
  logic g_out, h_out;
  logic g_ff, h_ff, g_aa, h_aa, g_55, h_55, g_00, h_00;

  int checks;
  int errors;

  logic [15:0] tt_g;
  logic [15:0] tt_h;

  main_mux8 dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .g_out(g_out), .h_out(h_out)
  );

  main_mux8 #(.G_TT(16'hFFFF)) dut_ff (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .g_out(g_ff), .h_out(h_ff)
  );

  main_mux8 #(.G_TT(16'hAAAA)) dut_aa (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .g_out(g_aa), .h_out(h_aa)
  );

  main_mux8 #(.G_TT(16'h5555)) dut_55 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .g_out(g_55), .h_out(h_55)
  );

  main_mux8 #(.G_TT(16'h0000)) dut_00 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .g_out(g_00), .h_out(h_00)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(4'b0001);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (g_out !== 1'b0 || h_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_cycle%0d: g=%b h=%b required g=0 h=0", k, g_out, h_out);
      end
      checks++;
      if (g_ff !== 1'b0 || g_55 !== 1'b0) begin
        errors++;
        $display("FAIL reset_override%0d: g_ff=%b g_55=%b required 0 0", k, g_ff, g_55);
      end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] v;
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) begin
      v = 4'(n);
      set_in(v);
      tick();
      checks++;
      if (g_out !== tt_g[n] || h_out !== tt_h[n]) begin
        errors++;
        $display("FAIL sweep_%b: g=%b h=%b required g=%b h=%b", v, g_out, h_out, tt_g[n], tt_h[n]);
      end
    end
  endtask

  task automatic test_spot();
    logic [3:0] vec [5];
    logic       eg  [5];
    vec[0] = 4'b0000; eg[0] = 1'b0;
    vec[1] = 4'b0001; eg[1] = 1'b1;
    vec[2] = 4'b0101; eg[2] = 1'b0;
    vec[3] = 4'b1110; eg[3] = 1'b1;
    vec[4] = 4'b1111; eg[4] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_in(vec[k]);
      tick();
      checks++;
      if (g_out !== eg[k] || h_out !== ~eg[k]) begin
        errors++;
        $display("FAIL spot_%b: g=%b h=%b required g=%b h=%b", vec[k], g_out, h_out, eg[k], ~eg[k]);
      end
    end
  endtask

  task automatic test_latency();
    set_in(4'b0000);
    tick();
    checks++;
    if (g_out !== 1'b0) begin
      errors++;
      $display("FAIL latency_base: g=%b required 0", g_out);
    end
    set_in(4'b0001);
    #2;
    checks++;
    if (g_out !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: g=%b required 0 before edge", g_out);
    end
    tick();
    checks++;
    if (g_out !== 1'b1) begin
      errors++;
      $display("FAIL latency_edge: g=%b required 1 after edge", g_out);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] v;
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) begin
      v = 4'(n);
      set_in(v);
      if (n == 9) begin
        rst_n = 1'b0;
        tick();
        checks++;
        if (g_out !== 1'b0 || h_out !== 1'b0) begin
          errors++;
          $display("FAIL midreset_hold: g=%b h=%b required g=0 h=0", g_out, h_out);
        end
        rst_n = 1'b1;
      end
      tick();
      checks++;
      if (g_out !== tt_g[n] || h_out !== tt_h[n]) begin
        errors++;
        $display("FAIL midreset_%b: g=%b h=%b required g=%b h=%b", v, g_out, h_out, tt_g[n], tt_h[n]);
      end
    end
  endtask

  task automatic test_override();
    logic [3:0] v;
    for (int n = 0; n < 16; n++) begin
      v = 4'(n);
      set_in(v);
      tick();
      checks++;
      if (g_ff !== 1'b1) begin
        errors++;
        $display("FAIL ovr_ffff_%b: g=%b required 1", v, g_ff);
      end
      checks++;
      if (g_aa !== v[0]) begin
        errors++;
        $display("FAIL ovr_aaaa_%b: g=%b required %b", v, g_aa, v[0]);
      end
      checks++;
      if (g_55 !== ~v[0]) begin
        errors++;
        $display("FAIL ovr_5555_%b: g=%b required %b", v, g_55, ~v[0]);
      end
      checks++;
      if (g_00 !== 1'b0) begin
        errors++;
        $display("FAIL ovr_0000_%b: g=%b required 0", v, g_00);
      end
    end
  endtask

  task automatic test_invariant();
    logic [3:0] v;
    int idx;
    for (int k = 0; k < 200; k++) begin
      v = 4'($urandom_range(0, 15));
      idx = int'(v);
      set_in(v);
      tick();
      checks++;
      if (g_out === h_out || g_out !== tt_g[idx]) begin
        errors++;
        $display("FAIL invariant_%0d_%b: g=%b h=%b required g=%b h=%b", k, v, g_out, h_out, tt_g[idx], ~tt_g[idx]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tt_g   = 16'hC39A;
    tt_h   = 16'h3C65;
    rst_n  = 1'b0;
    set_in(4'b0000);
    test_reset();
    test_sweep();
    test_spot();
    test_latency();
    test_mid_reset();
    test_override();
    test_invariant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
